// File: rtl/ulpi_pkg.sv
// Shared ULPI constants: TX CMD encodings, PHY register addresses and
// the register-sequencer state encodings.
package ulpi_pkg;

    localparam logic [7:0] CMD_NOPID = 8'h40;
    localparam logic [1:0] CMD_REGW  = 2'b10;
    localparam logic [1:0] CMD_REGR  = 2'b11;

    localparam logic [7:0] FUNC_CTRL = 8'h04;
    localparam logic [7:0] OTG_CTRL  = 8'h0A;

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_CMD   = 4'd1;
    localparam logic [3:0] ST_DATA  = 4'd2;
    localparam logic [3:0] ST_STOP  = 4'd3;
    localparam logic [3:0] ST_CHIRP = 4'd4;
    localparam logic [3:0] ST_TURN  = 4'd5;
    localparam logic [3:0] ST_RDATA = 4'd6;
    localparam logic [3:0] ST_ABORT = 4'd7;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_NOPID = 2'd2;

endpackage

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register sequencer: arbitrates port A (line-state FSM) and
// port B (core config) onto the TX bus for register writes, reads and NOPID.
module ulpi_reg_ctrl
    import ulpi_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_stp_o,
    input  logic       tx_active_i,
    input  logic       a_write_i,
    input  logic       a_nopid_i,
    input  logic       a_stop_i,
    input  logic [7:0] a_addr_i,
    input  logic [7:0] a_data_i,
    output logic       a_busy_o,
    output logic       a_done_o,
    input  logic       b_req_i,
    input  logic       b_read_i,
    input  logic [5:0] b_addr_i,
    input  logic [7:0] b_data_i,
    output logic       b_busy_o,
    output logic       b_done_o,
    output logic [7:0] b_rdata_o,
    output logic       err_o,
    output logic [3:0] state_o
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] RT_MAX  = 8'(RETRY_MAX);

    logic [3:0] state, state_d;
    logic [7:0] cmd_q, data_q;
    logic [1:0] op_q;
    logic       own_b;
    logic [7:0] tcnt, retry;

    logic       grant, grant_b, timed;
    logic       fin_ok, fin_err, chirp_done, retry_inc, cap, enter_stop;
    logic [7:0] cmd_sel, data_sel, bus_d;
    logic [1:0] op_sel;

    assign state_o = state;

    always_comb begin
        state_d    = state;
        grant      = 1'b0;
        grant_b    = 1'b0;
        fin_ok     = 1'b0;
        fin_err    = 1'b0;
        chirp_done = 1'b0;
        retry_inc  = 1'b0;
        cap        = 1'b0;
        cmd_sel    = a_write_i ? a_addr_i : CMD_NOPID;
        data_sel   = a_data_i;
        op_sel     = a_write_i ? OP_WRITE : OP_NOPID;
        timed      = (state == ST_CMD) || (state == ST_DATA) ||
                     (state == ST_TURN) || (state == ST_ABORT);

        case (state)
            ST_IDLE: begin
                if (!ulpi_dir && !tx_active_i) begin
                    if (a_write_i || a_nopid_i) begin
                        grant   = 1'b1;
                        state_d = ST_CMD;
                    end else if (b_req_i) begin
                        grant    = 1'b1;
                        grant_b  = 1'b1;
                        cmd_sel  = {(b_read_i ? CMD_REGR : CMD_REGW), b_addr_i};
                        data_sel = b_data_i;
                        op_sel   = b_read_i ? OP_READ : OP_WRITE;
                        state_d  = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (ulpi_dir) begin
                    state_d = ST_ABORT;
                end else if (ulpi_nxt) begin
                    case (op_q)
                        OP_WRITE: state_d = ST_DATA;
                        OP_READ:  state_d = ST_TURN;
                        default: begin
                            state_d    = ST_CHIRP;
                            chirp_done = 1'b1;
                        end
                    endcase
                end
            end
            ST_DATA: begin
                if (ulpi_dir)      state_d = ST_ABORT;
                else if (ulpi_nxt) state_d = ST_STOP;
            end
            ST_STOP:  state_d = ST_IDLE;
            ST_CHIRP: if (a_stop_i) state_d = ST_STOP;
            ST_TURN: begin
                if (ulpi_dir) state_d = ulpi_nxt ? ST_ABORT : ST_RDATA;
            end
            ST_RDATA: begin
                // The PHY dropping dir before the data cycle is treated as an abort.
                if (ulpi_dir) begin
                    cap     = 1'b1;
                    fin_ok  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (!ulpi_dir) begin
                    if (retry == RT_MAX) begin
                        fin_err = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        retry_inc = 1'b1;
                        state_d   = ST_CMD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout only fires when the cycle would otherwise stay put.
        if (timed && (state_d == state) && (tcnt == TO_LAST)) begin
            fin_err = 1'b1;
            state_d = ST_IDLE;
        end

        enter_stop = (state_d == ST_STOP) && (state != ST_STOP);

        case (state_d)
            ST_CMD:  bus_d = grant ? cmd_sel : cmd_q;
            ST_DATA: bus_d = data_q;
            default: bus_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cmd_q       <= '0;
            data_q      <= '0;
            op_q        <= OP_WRITE;
            own_b       <= 1'b0;
            tcnt        <= '0;
            retry       <= '0;
            ulpi_data_o <= '0;
            ulpi_stp_o  <= 1'b0;
            a_busy_o    <= 1'b0;
            a_done_o    <= 1'b0;
            b_busy_o    <= 1'b0;
            b_done_o    <= 1'b0;
            b_rdata_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            state       <= state_d;
            ulpi_data_o <= bus_d;
            ulpi_stp_o  <= (state_d == ST_STOP);
            err_o       <= fin_err;
            a_done_o    <= 1'b0;
            b_done_o    <= 1'b0;

            if (timed && (state_d == state)) tcnt <= tcnt + 8'd1;
            else                             tcnt <= '0;

            if (grant) begin
                cmd_q  <= cmd_sel;
                data_q <= data_sel;
                op_q   <= op_sel;
                own_b  <= grant_b;
                retry  <= '0;
                if (grant_b) b_busy_o <= 1'b1;
                else         a_busy_o <= 1'b1;
            end else if (retry_inc) begin
                retry <= retry + 8'd1;
            end

            if (enter_stop || fin_ok || fin_err || chirp_done) begin
                if (own_b) b_done_o <= 1'b1;
                else       a_done_o <= 1'b1;
            end
            if (enter_stop || fin_ok || fin_err) begin
                if (own_b) b_busy_o <= 1'b0;
                else       a_busy_o <= 1'b0;
            end

            if (cap) b_rdata_o <= ulpi_data_i;
        end
    end

endmodule
